// File: rtl/toycpu_core_hs_if.sv
// Ready/ack memory bus between toycpu_core_hs (master) and the board memory/IO decoder (slave).
// Every access holds bus_req until the cycle in which bus_ack is sampled high.
interface toycpu_core_hs_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/toycpu_core_hs.sv
// Parametrised toy CPU core: multi-cycle fetch/exec/mem FSM on a ready/ack bus, with HLT.
// Optional macro TOYCPU_RETIRE_CNT_EN adds a 32-bit retired-instruction counter output.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_FETCH | bus read at pc; ir loaded on ack
//   S_EXEC  | one cycle: ALU/LDI/MOV/SHL writeback, flags, pc <= next_pc
//   S_MEM   | LD reads mem[s] into d, ST writes s to mem[d]; leaves on ack
//   S_HALT  | stopped by HLT, no bus activity until reset
module toycpu_core_hs #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int NREGS  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  toycpu_core_hs_if.master       bus,
  output logic                   halted
`ifdef TOYCPU_RETIRE_CNT_EN
  ,
  output logic [31:0]            retire_cnt
`endif
);

  if (DATA_W < 16) begin : g_bad_data_w
    $error("toycpu_core_hs: DATA_W must be at least 16");
  end
  if (ADDR_W < 8) begin : g_bad_addr_w
    $error("toycpu_core_hs: ADDR_W must be at least 8");
  end
  if (NREGS != 4) begin : g_bad_nregs
    $error("toycpu_core_hs: NREGS must be 4 to match the 2-bit register fields");
  end

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_LD  = 4'h7;
  localparam logic [3:0] OP_ST  = 4'h8;
  localparam logic [3:0] OP_JMP = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_JC  = 4'hB;
  localparam logic [3:0] OP_JR  = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_SHL = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_ir;
  logic              r_c;
  logic              r_z;
  logic [DATA_W-1:0] r_regs [NREGS];

  logic [3:0]        w_op;
  logic [1:0]        w_d;
  logic [1:0]        w_s;
  logic [7:0]        w_imm;
  logic [DATA_W-1:0] w_rd;
  logic [DATA_W-1:0] w_rs;
  logic [ADDR_W-1:0] w_imm_addr;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_is_mem;

  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_c;
  logic              w_alu_z;
  logic              w_reg_wr;
  logic              w_flag_wr;

  logic              w_req;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  assign w_op       = r_ir[15:12];
  assign w_d        = r_ir[11:10];
  assign w_s        = r_ir[9:8];
  assign w_imm      = r_ir[7:0];
  assign w_rd       = r_regs[w_d];
  assign w_rs       = r_regs[w_s];
  assign w_imm_addr = ADDR_W'(w_imm);
  assign w_is_mem   = (w_op == OP_LD) || (w_op == OP_ST);

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_reg_wr  = 1'b0;
    w_flag_wr = 1'b0;
    case (w_op)
      OP_ADD: begin
        {w_alu_c, w_alu_res} = {1'b0, w_rd} + {1'b0, w_rs};
        w_reg_wr  = 1'b1;
        w_flag_wr = 1'b1;
      end
      OP_SUB: begin
        w_alu_res = w_rd - w_rs;
        w_alu_c   = (w_rd < w_rs);
        w_reg_wr  = 1'b1;
        w_flag_wr = 1'b1;
      end
      OP_AND: begin
        w_alu_res = w_rd & w_rs;
        w_reg_wr  = 1'b1;
        w_flag_wr = 1'b1;
      end
      OP_OR: begin
        w_alu_res = w_rd | w_rs;
        w_reg_wr  = 1'b1;
        w_flag_wr = 1'b1;
      end
      OP_XOR: begin
        w_alu_res = w_rd ^ w_rs;
        w_reg_wr  = 1'b1;
        w_flag_wr = 1'b1;
      end
      OP_LDI: begin
        w_alu_res = DATA_W'(w_imm);
        w_reg_wr  = 1'b1;
      end
      OP_MOV: begin
        w_alu_res = w_rs;
        w_reg_wr  = 1'b1;
      end
      OP_SHL: begin
        w_alu_res = {w_rd[DATA_W-2:0], 1'b0};
        w_alu_c   = w_rd[DATA_W-1];
        w_reg_wr  = 1'b1;
        w_flag_wr = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_alu_z = (w_alu_res == '0);

  always_comb begin
    w_pc_nxt = r_pc + 1'b1;
    case (w_op)
      OP_JMP:  w_pc_nxt = w_imm_addr;
      OP_JZ:   if (r_z) w_pc_nxt = w_imm_addr;
      OP_JC:   if (r_c) w_pc_nxt = w_imm_addr;
      OP_JR:   w_pc_nxt = ADDR_W'(w_rs);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_we        = 1'b0;
    w_addr      = r_pc;
    w_wdata     = '0;
    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (bus.bus_ack) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (w_is_mem)              w_state_nxt = S_MEM;
        else if (w_op == OP_HLT)   w_state_nxt = S_HALT;
        else                       w_state_nxt = S_FETCH;
      end
      S_MEM: begin
        w_req = 1'b1;
        if (w_op == OP_ST) begin
          w_we    = 1'b1;
          w_addr  = ADDR_W'(w_rd);
          w_wdata = w_rs;
        end else begin
          w_addr  = ADDR_W'(w_rs);
        end
        if (bus.bus_ack) w_state_nxt = S_FETCH;
      end
      S_HALT: ;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Gating with rst drops the request the instant reset asserts, before any edge.
  assign bus.bus_req   = w_req & rst;
  assign bus.bus_we    = w_we;
  assign bus.bus_addr  = w_addr;
  assign bus.bus_wdata = w_wdata;
  assign halted        = (r_state == S_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= '0;
      r_ir <= '0;
      r_c  <= 1'b0;
      r_z  <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (bus.bus_ack) r_ir <= bus.bus_rdata[15:0];
        end
        S_EXEC: begin
          r_pc <= w_pc_nxt;
          if (w_reg_wr) r_regs[w_d] <= w_alu_res;
          if (w_flag_wr) begin
            r_c <= w_alu_c;
            r_z <= w_alu_z;
          end
        end
        S_MEM: begin
          if (bus.bus_ack && (w_op == OP_LD)) r_regs[w_d] <= bus.bus_rdata;
        end
        default: ;
      endcase
    end
  end

`ifdef TOYCPU_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;
  logic        w_retire;

  assign w_retire = ((r_state == S_EXEC) && !w_is_mem) ||
                    ((r_state == S_MEM) && bus.bus_ack);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retire_cnt <= '0;
    end else if (w_retire) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: doc/toycpu_core_hs.md
Name: toycpu_core_hs

Overview:
- Parametrised successor to the toy CPU core, with configurable data/address width and register count.
- Multi-cycle fetch/execute/memory FSM on a ready/ack memory bus, so RAM or peripherals may insert any number of wait states.
- Adds a halt instruction and a halted status output.
- Sits between the board-level memory/IO decoder and nothing else: one bus master, one clock.

Parameters:
- DATA_W, 16, register/ALU/bus data width; min 16; instruction is the low 16 bits of the fetched word.
- ADDR_W, 16, bus address width and PC width; min 8.
- NREGS, 4, number of general registers; must be 4 (2-bit reg fields), kept as a parameter for regfile sizing checks.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- bus_req  out  1  bus access request; held until ack.
- bus_we  out  1  1 = write, 0 = read; valid while bus_req.
- bus_addr  out  ADDR_W  access address; valid while bus_req.
- bus_wdata  out  DATA_W  write data; valid while bus_req & bus_we.
- bus_rdata  in  DATA_W  read data; sampled on the edge where bus_ack=1.
- bus_ack  in  1  access complete; ignored when bus_req=0.
- halted  out  1  core stopped by HLT.

Behaviour:
- Instruction format: [15:12] op, [11:10] d, [9:8] s, [7:0] imm8. imm8 is zero-extended to the destination width.
- Opcodes:
  - 0 NOP.
  - 1 ADD: d=d+s; C=carry out, Z updated.
  - 2 SUB: d=d-s; C=1 iff d<s unsigned, Z updated.
  - 3 AND, 4 OR, 5 XOR: d=d op s; C=0, Z updated.
  - 6 LDI: d=imm8.
  - 7 LD: d=mem[s].
  - 8 ST: mem[d]=s.
  - 9 JMP: pc=imm8.
  - A JZ: jump to imm8 if Z=1.
  - B JC: jump to imm8 if C=1.
  - C JR: pc=s[ADDR_W-1:0].
  - D MOV: d=s.
  - E SHL: d=d<<1; C=old msb, Z updated.
  - F HLT.
- Flags change only on ops 1-5 and E. Z = (result == 0) over DATA_W bits.
- Reset (rst=0, async): pc=0, all regs=0, C=Z=0, ir=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, halted=0, state=FETCH.
- FSM states: FETCH, EXEC, MEM, HALT.
- FETCH:
  - bus_req=1, bus_we=0, bus_addr=pc.
  - On the edge with bus_ack=1: ir<=bus_rdata[15:0], go to EXEC.
  - bus_req drops in the EXEC cycle.
- EXEC (exactly 1 cycle):
  - Register/flag writeback for ALU, LDI, MOV, SHL.
  - pc<=next_pc: jump target if taken, else pc+1, wrapping modulo 2^ADDR_W.
  - LD/ST go to MEM with pc already advanced. HLT goes to HALT. All others go to FETCH.
- MEM:
  - LD: bus_addr=s, bus_we=0; on ack, d<=bus_rdata.
  - ST: bus_addr=d, bus_we=1, bus_wdata=s.
  - Addresses use the low ADDR_W bits of the register.
  - On ack, go to FETCH.
- HALT: halted=1, bus_req=0; stays until reset.
- Bus rules:
  - bus_addr, bus_we and bus_wdata are stable for the whole request.
  - Zero-wait-state ack (ack high in the first req cycle) is legal.
  - Minimum time per instruction: ALU/jump 2 cycles, LD/ST 3 cycles.
- Boundary cases:
  - pc=2^ADDR_W-1 with a non-jump wraps to 0.
  - LD with d==s writes the loaded value.
  - ST uses register values as they stand at MEM entry.
  - Reset asserted mid-request drops bus_req asynchronously; no write is considered committed unless ack was sampled.
  - bus_ack while bus_req=0 has no effect.

Optional Feature:
- Macro: TOYCPU_RETIRE_CNT_EN.
- When defined:
  - Extra output retire_cnt (32 bits).
  - Reset value 0.
  - Increments by 1 on every instruction completion: EXEC exit for non-memory ops, MEM ack for LD/ST, HLT counted on entry to HALT.
  - Wraps at 2^32.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, memory acks every cycle, program LDI r0,5; LDI r1,3; ADD r0,r1; HLT -> r0=8, C=0, Z=0, halted=1 after 8 cycles; bus_req=0 thereafter.
- Same program with memory inserting 3 wait states per access -> identical final state; bus_addr stable across every wait cycle; halted=1 after 20 cycles.
- LDI r0,0xFF; LDI r1,0x01; ADD r0,r1 with DATA_W=8 override -> illegal (min 16); with DATA_W=16 and r0 preloaded to 0xFFFF via LD -> r0=0, C=1, Z=1; following JZ 0x40 fetches from 0x0040.
- LDI r2,0x80; LDI r3,0xAB; ST r2,r3; LD r1,r2 -> write to 0x0080 with data 0x00AB; r1=0x00AB.
- JMP 0xFF at pc=0xFFFF with ADDR_W=16 -> next fetch 0x00FF; a NOP at 0xFFFF -> next fetch 0x0000.
- Assert rst low during a FETCH wait state -> bus_req=0 immediately; after release, first fetch at address 0; with TOYCPU_RETIRE_CNT_EN defined, retire_cnt=0 after reset and equals 4 after the first program.
